// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles a fetch request has been denied.
module mem_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic starved
);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || i_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign starved = (wait_cnt_q == WAIT_MAX);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between fetch (read-only) and load/store,
// data first, with a starvation bound for fetch and 1-cycle read routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT    = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       starved;
  logic       arb_en;
  logic       i_win;

  // Handshake: a request is accepted in the cycle its gnt is 1 (combinational
  // on req); the requester holds req/addr/we/wdata until then. rvalid is a
  // one-cycle pulse the cycle after a granted read; there is no back-pressure.

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q - 4'd1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Gating with rst_n keeps the RAM untouched in a reset cycle.
  always_comb begin
    arb_en = rst_n && (state_q == ST_RUN);
    i_win  = i_req && (!d_req || starved);
    i_gnt  = arb_en && i_win;
    d_gnt  = arb_en && d_req && !i_win;
  end

  always_comb begin
    mem_cs   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (i_gnt) begin
      mem_cs   = 1'b1;
      mem_oe   = 1'b1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_cs   = 1'b1;
      mem_oe   = !d_we;
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_din  = d_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (i_gnt) begin
      rd_owner_d = OWN_IFETCH;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LOAD;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    i_rvalid = rst_n && (rd_owner_q == OWN_IFETCH);
    d_rvalid = rst_n && (rd_owner_q == OWN_DATA);
    i_rdata  = i_rvalid ? mem_dout : '0;
    d_rdata  = d_rvalid ? mem_dout : '0;
  end

  mem_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_gnt  (i_gnt),
    .starved(starved)
  );
endmodule
